// File: rtl/genesis_pad_pkg.sv
// Shared constants and the pin-mapping helper for the Genesis/Mega Drive pad responder.
package genesis_pad_pkg;

  localparam int BT_UP    = 0;
  localparam int BT_DOWN  = 1;
  localparam int BT_LEFT  = 2;
  localparam int BT_RIGHT = 3;
  localparam int BT_A     = 4;
  localparam int BT_B     = 5;
  localparam int BT_C     = 6;
  localparam int BT_START = 7;
  localparam int BT_X     = 8;
  localparam int BT_Y     = 9;
  localparam int BT_Z     = 10;
  localparam int BT_MODE  = 11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 75000;

  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_ONE   = 3'd1,
    E_TWO   = 3'd2,
    E_EXTRA = 3'd3,
    E_DONE  = 3'd4
  } phase_e;

  typedef struct packed {
    logic p9;
    logic p6;
    logic p4;
    logic p3;
    logic p2;
    logic p1;
  } pins_t;

  // Active-low DB9 levels for a given Select level, falling-edge count and button set.
  function automatic pins_t pad_pins(input logic sel, input phase_e e, input logic [11:0] b);
    pins_t p;
    p.p6 = sel ? ~b[BT_B] : ~b[BT_A];
    p.p9 = sel ? ~b[BT_C] : ~b[BT_START];
    if (sel) begin
      if (e == E_EXTRA) begin
        p.p1 = ~b[BT_Z];
        p.p2 = ~b[BT_Y];
        p.p3 = ~b[BT_X];
        p.p4 = ~b[BT_MODE];
      end else begin
        p.p1 = ~b[BT_UP];
        p.p2 = ~b[BT_DOWN];
        p.p3 = ~b[BT_LEFT];
        p.p4 = ~b[BT_RIGHT];
      end
    end else begin
      case (e)
        E_EXTRA: {p.p4, p.p3, p.p2, p.p1} = 4'b0000;
        E_DONE:  {p.p4, p.p3, p.p2, p.p1} = 4'b1111;
        default: {p.p4, p.p3, p.p2, p.p1} = {2'b00, ~b[BT_DOWN], ~b[BT_UP]};
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/genesis_pad_responder_sync_2ff.sv
// Two-flop synchronizer with a parameterised width and reset value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: non-blocking assignments so both stages sample their old values on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/genesis_pad_responder.sv
// Peripheral side of the DB9 Select protocol: counts Select falls, times out, drives the pins.
module genesis_pad_responder
  import genesis_pad_pkg::*;
#(
  parameter bit MODO6          = 1'b1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CW             = 17
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        Select,
  input  logic [11:0] Botoes,
  output logic        Pino1,
  output logic        Pino2,
  output logic        Pino3,
  output logic        Pino4,
  output logic        Pino6,
  output logic        Pino9,
  output logic [2:0]  Fase
);

  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic        sel_s;
  logic [11:0] btn_s;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_sel (
    .clk (Clock50),
    .rst (Reset),
    .d   (Select),
    .q   (sel_s)
  );

  sync_2ff #(.W(12), .RST_VAL(12'h000)) u_sync_btn (
    .clk (Clock50),
    .rst (Reset),
    .d   (Botoes),
    .q   (btn_s)
  );

  logic          sel_prev_d, sel_prev_q;
  logic [CW-1:0] tmo_d, tmo_q;
  phase_e        e_d, e_q;
  pins_t         pins_d, pins_q;
  logic          sel_edge, sel_fall, expired;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_prev_d = sel_s;
    sel_edge   = sel_s ^ sel_prev_q;
    sel_fall   = sel_prev_q & ~sel_s;
    expired    = (tmo_q == TMO_MAX);

    tmo_d = tmo_q;
    if (sel_edge)      tmo_d = '0;
    else if (!expired) tmo_d = tmo_q + CW'(1);

    // A fall on the expiry cycle wins: it starts a fresh sequence at E=1.
    e_d = e_q;
    if (!MODO6)             e_d = E_IDLE;
    else if (sel_fall) begin
      if (expired)          e_d = E_ONE;
      else if (e_q != E_DONE) e_d = phase_e'(e_q + 3'd1);
    end else if (expired)   e_d = E_IDLE;

    // Pins use the next E so they change on the same edge as Fase.
    pins_d = pad_pins(sel_s, e_d, btn_s);
  end

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      sel_prev_q <= 1'b1;
      tmo_q      <= '0;
      e_q        <= E_IDLE;
      pins_q     <= '1;
    end else begin
      sel_prev_q <= sel_prev_d;
      tmo_q      <= tmo_d;
      e_q        <= e_d;
      pins_q     <= pins_d;
    end
  end

  assign Pino1 = pins_q.p1;
  assign Pino2 = pins_q.p2;
  assign Pino3 = pins_q.p3;
  assign Pino4 = pins_q.p4;
  assign Pino6 = pins_q.p6;
  assign Pino9 = pins_q.p9;
  assign Fase  = e_q;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Bench for genesis_pad_responder: three configurations against a cycle-level behavioural model.
module tb_genesis_pad_responder;

  localparam int T_MAIN  = 75000;
  localparam int T_SHORT = 64;

  logic        Clock50 = 1'b0;
  logic        Reset;
  logic        Select;
  logic [11:0] Botoes;

  // Pin vectors are {P9,P6,P4,P3,P2,P1}.
  logic [5:0] pa, pb, pc;
  logic [2:0] fa, fb, fc;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 Clock50 = ~Clock50;

  genesis_pad_responder #(.MODO6(1'b1), .TIMEOUT_CYCLES(T_MAIN), .CW(17)) dut_main (
    .Clock50(Clock50), .Reset(Reset), .Select(Select), .Botoes(Botoes),
    .Pino1(pa[0]), .Pino2(pa[1]), .Pino3(pa[2]), .Pino4(pa[3]), .Pino6(pa[4]), .Pino9(pa[5]),
    .Fase(fa)
  );

  genesis_pad_responder #(.MODO6(1'b1), .TIMEOUT_CYCLES(T_SHORT), .CW(7)) dut_short (
    .Clock50(Clock50), .Reset(Reset), .Select(Select), .Botoes(Botoes),
    .Pino1(pb[0]), .Pino2(pb[1]), .Pino3(pb[2]), .Pino4(pb[3]), .Pino6(pb[4]), .Pino9(pb[5]),
    .Fase(fb)
  );

  genesis_pad_responder #(.MODO6(1'b0), .TIMEOUT_CYCLES(T_MAIN), .CW(17)) dut_m3 (
    .Clock50(Clock50), .Reset(Reset), .Select(Select), .Botoes(Botoes),
    .Pino1(pc[0]), .Pino2(pc[1]), .Pino3(pc[2]), .Pino4(pc[3]), .Pino6(pc[4]), .Pino9(pc[5]),
    .Fase(fc)
  );

  // Behavioural model: Select/Botoes seen two clocks late, E and idle time as plain integers.
  typedef struct {
    bit [2:0]  sel_hist;   // [0] newest sample
    bit [11:0] btn_new;
    bit [11:0] btn_old;
    int        e;
    int        idle;
    bit [5:0]  pins;
  } model_t;

  function automatic model_t model_step(model_t m, bit rst, bit sel, bit [11:0] bt,
                                        bit modo6, int tmo);
    model_t n;
    bit cur, prev, expired;
    bit [11:0] b;
    bit p1, p2, p3, p4, p6, p9;
    n = m;
    if (rst) begin
      n.sel_hist = 3'b111;
      n.btn_new  = '0;
      n.btn_old  = '0;
      n.e        = 0;
      n.idle     = 0;
      n.pins     = 6'h3F;
      return n;
    end
    cur     = m.sel_hist[1];
    prev    = m.sel_hist[2];
    b       = m.btn_old;
    expired = (m.idle >= tmo - 1);
    if (prev != cur)  n.idle = 0;
    else if (!expired) n.idle = m.idle + 1;
    if (!modo6)                n.e = 0;
    else if (prev && !cur)     n.e = expired ? 1 : ((m.e >= 4) ? 4 : m.e + 1);
    else if (expired)          n.e = 0;
    if (cur) begin
      p6 = !b[5]; p9 = !b[6];
      if (n.e == 3) begin p1 = !b[10]; p2 = !b[9]; p3 = !b[8]; p4 = !b[11]; end
      else          begin p1 = !b[0];  p2 = !b[1]; p3 = !b[2]; p4 = !b[3];  end
    end else begin
      p6 = !b[4]; p9 = !b[7];
      if (n.e == 3)      begin p1 = 0; p2 = 0; p3 = 0; p4 = 0; end
      else if (n.e == 4) begin p1 = 1; p2 = 1; p3 = 1; p4 = 1; end
      else               begin p1 = !b[0]; p2 = !b[1]; p3 = 0; p4 = 0; end
    end
    n.pins     = {p9, p6, p4, p3, p2, p1};
    n.sel_hist = {m.sel_hist[1], m.sel_hist[0], sel};
    n.btn_old  = m.btn_new;
    n.btn_new  = bt;
    return n;
  endfunction

  model_t ma, mb, mc;
  bit     mvalid = 1'b0;

  always @(posedge Clock50) begin
    ma = model_step(ma, Reset, Select, Botoes, 1'b1, T_MAIN);
    mb = model_step(mb, Reset, Select, Botoes, 1'b1, T_SHORT);
    mc = model_step(mc, Reset, Select, Botoes, 1'b0, T_MAIN);
    if (Reset) mvalid = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge Clock50) begin
    if (mvalid) begin
      check("model_main",  {23'd0, pa, fa}, {23'd0, ma.pins, 3'(ma.e)});
      check("model_short", {23'd0, pb, fb}, {23'd0, mb.pins, 3'(mb.e)});
      check("model_modo3", {23'd0, pc, fc}, {23'd0, mc.pins, 3'(mc.e)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock50);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
  endtask

  initial begin
    bit found;
    Reset  = 1'b1;
    Select = 1'b1;
    Botoes = 12'h000;
    cyc(4);
    check("reset_pins", 32'(pa), 32'h3F);
    check("reset_fase", 32'(fa), 32'h0);
    Select = 1'b0;
    cyc(4);
    check("reset_sel_low_pins", 32'(pa), 32'h3F);
    check("reset_sel_low_m3", 32'(pc), 32'h3F);
    Select = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(5);

    // Up+A: latency of the first falling edge
    Botoes = 12'h011;
    cyc(5);
    check("idle_high_upA", 32'(pa), 32'h3E);
    Select = 1'b0;
    cyc(2);
    check("latency_not_yet", 32'(fa), 32'h0);
    cyc(1);
    check("first_fall_pins", 32'(pa), 32'h22);
    check("first_fall_fase", 32'(fa), 32'h1);
    Select = 1'b1;
    cyc(100);

    // Z pressed, four low pulses
    pulse_reset();
    Botoes = 12'h400;
    cyc(5);
    for (int i = 0; i < 4; i++) begin
      Select = 1'b0;
      cyc(50);
      if (i == 2) begin
        check("id_phase_p1_4", 32'(pa[3:0]), 32'h0);
        check("id_phase_fase", 32'(fa), 32'h3);
      end
      if (i == 3) begin
        check("done_p1_4", 32'(pa[3:0]), 32'hF);
        check("done_fase", 32'(fa), 32'h4);
      end
      cyc(50);
      Select = 1'b1;
      cyc(50);
      if (i == 2) check("extra_high_p1_4", 32'(pa[3:0]), 32'hE);
      cyc(50);
    end

    // E=4 held until timeout
    cyc(74800);
    check("before_timeout_fase", 32'(fa), 32'h4);
    cyc(200);
    check("after_timeout_fase", 32'(fa), 32'h0);
    Select = 1'b0;
    cyc(3);
    check("post_timeout_low_p1_4", 32'(pa[3:0]), 32'h3);
    check("post_timeout_fase", 32'(fa), 32'h1);
    Select = 1'b1;
    cyc(20);

    // 3-button instance ignores the edge count
    pulse_reset();
    Botoes = 12'hF00;
    cyc(5);
    for (int i = 0; i < 6; i++) begin
      Select = 1'b0;
      cyc(5);
      check("m3_low_p1_4", 32'(pc[3:0]), 32'h3);
      cyc(5);
      Select = 1'b1;
      cyc(5);
      check("m3_high_p1_4", 32'(pc[3:0]), 32'hF);
      check("m3_fase", 32'(fc), 32'h0);
      cyc(5);
    end

    // Reset mid-sequence at E=2
    pulse_reset();
    cyc(5);
    for (int i = 0; i < 2; i++) begin
      Select = 1'b0; cyc(10);
      Select = 1'b1; cyc(10);
    end
    check("mid_seq_fase2", 32'(fa), 32'h2);
    pulse_reset();
    cyc(3);
    check("mid_seq_reset_fase", 32'(fa), 32'h0);
    Select = 1'b0;
    cyc(3);
    check("mid_seq_next_fall", 32'(fa), 32'h1);
    Select = 1'b1;
    cyc(10);

    // Fall landing exactly on timeout expiry (short instance)
    pulse_reset();
    cyc(5);
    for (int i = 0; i < 4; i++) begin
      Select = 1'b0; cyc(5);
      Select = 1'b1; cyc(5);
    end
    check("short_done_fase", 32'(fb), 32'h4);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mb.idle == T_SHORT - 3) found = 1'b1;
      else cyc(1);
    end
    check("expiry_wait_bound", 32'(found), 32'h1);
    Select = 1'b0;
    cyc(2);
    check("expiry_before_fase", 32'(fb), 32'h4);
    cyc(1);
    check("expiry_edge_wins_fase", 32'(fb), 32'h1);
    cyc(30);
    Select = 1'b1;
    cyc(90);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      Select = ~Select;
      Botoes = 12'($urandom);
      if ($urandom_range(0, 40) == 0) pulse_reset();
      if ($urandom_range(0, 15) == 0) cyc($urandom_range(60, 70));
      else cyc($urandom_range(1, 12));
    end
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
